// File: rtl/hqc_msg_serializer.sv
// Serializes the decrypted HQC message m' into 32-bit little-endian words for the G-function hash core.
// Define HQC_MSG_SERIAL_DOMAIN_SEP_EN to append the domain-separator byte as an extra final word.
module hqc_msg_serializer #(
  parameter string       parameter_set = "hqc128",
  parameter logic [7:0]  DOMAIN_BYTE   = 8'h03,
  localparam int         K_BYTES       = (parameter_set == "hqc256") ? 32 :
                                         (parameter_set == "hqc192") ? 24 : 16,
  localparam int         K             = 8 * K_BYTES,
  localparam int         NWORDS        = K / 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [K-1:0] msg_i,
  input  logic         msg_valid_i,
  output logic [31:0]  dout_o,
  output logic         dout_valid_o,
  input  logic         dout_ready_i,
  output logic         dout_last_o,
  output logic [2:0]   dout_bytes_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         overrun_o
);

`ifdef HQC_MSG_SERIAL_DOMAIN_SEP_EN
  localparam bit DOMAIN_SEP_EN = 1'b1;
`else
  localparam bit DOMAIN_SEP_EN = 1'b0;
`endif

  localparam int NXFER = DOMAIN_SEP_EN ? NWORDS + 1 : NWORDS;
  localparam int CW    = $clog2(NWORDS + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(NXFER - 1);
  localparam logic [CW-1:0] LAST_MSG = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [K-1:0]   msg_q, msg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic [2:0]     bytes_q, bytes_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;
  logic           xfer;

  assign xfer = valid_q & dout_ready_i;

  // Every output is taken straight from a flop; the next-word values are
  // precomputed here so dout_ready_i never reaches an output combinationally.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    msg_d     = msg_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    last_d    = last_q;
    bytes_d   = bytes_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (msg_valid_i) begin
          state_d = SEND;
          msg_d   = msg_i;
          cnt_d   = '0;
          dout_d  = msg_i[31:0];
          valid_d = 1'b1;
          last_d  = (NXFER == 1);
          bytes_d = 3'd4;
        end
      end

      SEND: begin
        if (msg_valid_i) overrun_d = 1'b1;
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            msg_d   = '0;
            dout_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            bytes_d = 3'd0;
            done_d  = 1'b1;
          end else begin
            msg_d = msg_q >> 32;
            if (DOMAIN_SEP_EN && cnt_q == LAST_MSG) begin
              dout_d  = {24'h0, DOMAIN_BYTE};
              bytes_d = 3'd1;
              last_d  = 1'b1;
            end else begin
              dout_d  = msg_q[63:32];
              bytes_d = 3'd4;
              last_d  = (cnt_d == LAST_IDX);
            end
          end
        end
      end

      DONE: begin
        if (msg_valid_i) overrun_d = 1'b1;
        state_d = IDLE;
        msg_d   = '0;
      end

      default: begin
        state_d = IDLE;
        msg_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: msg_q holds secret material, so it is cleared by reset as well as after transfer.
      state_q   <= IDLE;
      msg_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      bytes_q   <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      msg_q     <= msg_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      bytes_q   <= bytes_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign dout_last_o  = last_q;
  assign dout_bytes_o = bytes_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/hqc_msg_serializer.md
# hqc_msg_serializer

Captures the K-bit message m' produced by the decrypt stage (decoder output plus its one-cycle valid pulse) and streams it as 32-bit words over a valid/ready interface into the SHAKE256-based G function that re-derives theta for FO re-encryption. Sits directly downstream of decrypt in the decapsulation datapath. It holds m' in a local register so the decoder can be reused immediately, and it zeroizes that register after transfer.

## Interface
- parameter_set, "hqc128": selects K_BYTES; "hqc128"/"hqc192"/"hqc256" give 16/24/32.
- K_BYTES, derived (16/24/32): message bytes.
- K, 8*K_BYTES: message bits.
- NWORDS, K/32 (4/6/8): 32-bit message words.
- DOMAIN_BYTE, 8'h03: G-function domain separator; used only with the macro below.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- msg_i  in  K  decrypted message; sampled only when msg_valid_i=1.
- msg_valid_i  in  1  one-cycle pulse from decrypt done.
- dout_o  out  32  output word, little-endian: word j = msg_i[32j+31:32j], byte 0 in bits [7:0].
- dout_valid_o  out  1  word on dout_o is valid.
- dout_ready_i  in  1  hash core accepts the word.
- dout_last_o  out  1  current word is the final word of the message.
- dout_bytes_o  out  3  valid bytes in dout_o (1..4), LSB-aligned.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle pulse after the last word is accepted.
- overrun_o  out  1  sticky; set when msg_valid_i arrives while busy_o=1.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE → SEND when msg_valid_i=1. Latch msg_i into shift register msg_q and clear word counter cnt.
- SEND: dout_valid_o=1, dout_o=msg_q[31:0], dout_bytes_o=4.
- A transfer is the condition dout_valid_o & dout_ready_i. On each transfer, msg_q shifts right by 32 with zero fill, and cnt increments.
- The last message word is cnt=NWORDS-1.
- Leave SEND for DONE on the transfer of the final word, with dout_last_o asserted on that word.
- DONE: done_o=1 and msg_q zeroized, for exactly one cycle, then → IDLE.
- Stall: when dout_valid_o=1 and dout_ready_i=0, dout_o, dout_last_o, dout_bytes_o and cnt are held unchanged. dout_valid_o never drops before a transfer.
- msg_valid_i while in SEND or DONE: ignored. msg_q is not overwritten and overrun_o is set to 1. overrun_o clears only on reset.
- cnt width is clog2(NWORDS+1). It never wraps because exit occurs at its terminal value.
- Reset, including mid-SEND: state=IDLE, msg_q=0, cnt=0. No done_o is produced for the aborted message.

## Timing
- Reset value of every output is 0: dout_o, dout_valid_o, dout_last_o, dout_bytes_o, busy_o, done_o, overrun_o.
- msg_valid_i at cycle t → dout_valid_o=1 with word 0 at t+1, and busy_o=1 from t+1.
- With dout_ready_i held at 1, one word is transferred per cycle.
- Last transfer at cycle L → done_o=1 at L+1, busy_o=0 at L+2. A new msg_valid_i is accepted at L+2 or later.
- Minimum gap between consecutive accepted messages: NWORDS+2 cycles, or NWORDS+3 with the domain-separation feature compiled in.
- All outputs are registered. There is no combinational path from dout_ready_i to dout_valid_o or to dout_o.

## Configuration
- HQC_MSG_SERIAL_DOMAIN_SEP_EN defined: after word NWORDS-1, emit one extra word.
  - dout_o={24'h0,DOMAIN_BYTE}, dout_bytes_o=1, dout_last_o=1.
  - dout_last_o is 0 on message words.
  - Total NWORDS+1 transfers.
- Not defined: exactly NWORDS transfers, and dout_last_o=1 on word NWORDS-1.
- The domain byte is then appended by the hash wrapper.

## Test plan
- hqc128, macro off, ready=1, msg_i=128'h0F0E..0100:
  - dout_o sequence 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C on t+1..t+4, with last only on 4th.
  - done_o at t+5, busy_o=0 at t+6.
- hqc256, macro on:
  - 9 transfers; the 9th is dout_o=32'h00000003, dout_bytes_o=1, last=1.
  - done_o is 1 cycle after it.
- Backpressure: ready=0 for 5 cycles on word 2 → dout_o and dout_valid_o are stable throughout, no word is skipped or duplicated, and done_o is delayed by exactly 5 cycles.
- Overrun: second msg_valid_i during SEND with different data → output stream still carries the first message, and overrun_o=1 until reset.
- Reset mid-stream: rst_ni=0 after word 1 → next cycle all outputs are 0 and no done_o appears. A subsequent message streams correctly from word 0.
- Zeroization: after done_o, internal msg_q reads 0, and back-to-back messages at the minimum gap are both delivered intact.
